match_collector: RTL and testbench
==================================

MATCH_COLLECTOR -- requirements
Module: match_collector

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning match FIFO entries (power of two, 4..64).
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning match address width.
REQ-003 The block SHALL have port CLK100MHZ  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous assert, active-low (one clock; reset asynchronous, active-low).
REQ-005 The block SHALL have port start  input  1  single-cycle pulse that opens a new collection run.
REQ-006 The block SHALL have port match_valid  input  1  the search engine reports one match this cycle.
REQ-007 The block SHALL have port match_addr  input  ADDR_W  memory address of the reported match.
REQ-008 The block SHALL have port search_done  input  1  the search engine has finished scanning its block.
REQ-009 The block SHALL have port out_ready  input  1  the consumer accepts out_addr this cycle.
REQ-010 The block SHALL have port out_valid  output  1  out_addr holds a stored match.
REQ-011 The block SHALL have port out_addr  output  ADDR_W  oldest stored match address.
REQ-012 The block SHALL have port match_count  output  8  matches accepted this run, saturating at 255.
REQ-013 The block SHALL have port overflow  output  1  sticky: a match was dropped because the FIFO was full.
REQ-014 The block SHALL have port run_done  output  1  high in DONE state.

Function
REQ-015 The block SHALL implement states IDLE, COLLECT, DRAIN and DONE.
REQ-016 IDLE SHALL go to COLLECT on start, clearing the FIFO, match_count and overflow in that same edge.
REQ-017 COLLECT SHALL write match_addr into the FIFO on each cycle with match_valid=1 and FIFO not full, and increment match_count.
REQ-018 COLLECT SHALL go to DRAIN on search_done; a match_valid in the same cycle SHALL still be stored.
REQ-019 DRAIN SHALL go to DONE in the cycle after the FIFO becomes empty; DONE SHALL return to IDLE on start, with start in DONE acting as in IDLE.
REQ-020 match_valid outside COLLECT SHALL be ignored and SHALL NOT count.
REQ-021 A match with the FIFO full SHALL be dropped, SHALL set overflow and SHALL NOT increment match_count.
REQ-022 out_valid SHALL equal "FIFO not empty" in every state; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-023 out_addr SHALL be first-word-fall-through, valid in the same cycle as out_valid with zero added latency; a written entry SHALL be visible one cycle after the write.
REQ-024 A simultaneous push and pop SHALL both take effect, leaving occupancy unchanged, including when the FIFO is full.
REQ-025 Read and write pointers SHALL be log2(DEPTH)+1 bits, wrap modulo 2*DEPTH, and set full/empty by MSB comparison.
REQ-026 start in COLLECT or DRAIN SHALL abort the run, flush the FIFO and restart COLLECT.

Reset
REQ-027 On reset_n=0, the block SHALL asynchronously set state=IDLE, pointers=0, out_valid=0, out_addr=0, match_count=0, overflow=0 and run_done=0.
REQ-028 Reset asserted mid-run SHALL discard all stored matches with no out_valid pulse.

Configuration
REQ-029 With MATCH_COLLECTOR_DEDUP_EN defined, a match_addr equal to the last accepted address in this run SHALL be dropped, without counting and without setting overflow.
REQ-030 Without MATCH_COLLECTOR_DEDUP_EN, every match_valid in COLLECT SHALL be treated per REQ-017/REQ-021.

Structure
REQ-031 The state enumeration, DEPTH and ADDR_W defaults and the match_count width SHALL live in shared package psa_pkg.
REQ-032 The FIFO storage and pointers SHALL be a sub-module named match_fifo; control, counting and dedup SHALL stay in match_collector.

Verification
REQ-033 The bench SHALL cover: start; matches 0x05, 0x09, 0x11; search_done; out_ready=1 -> out_addr 0x05, 0x09, 0x11 in order, match_count=3, run_done one cycle after the last pop.
REQ-034 The bench SHALL cover: DEPTH=16, out_ready=0, 18 matches -> 16 stored, match_count=16, overflow=1, the first 16 addresses drained in order.
REQ-035 The bench SHALL cover: FIFO full, match_valid and out_ready both 1 in one cycle -> occupancy stays 16 and overflow stays 0.
REQ-036 The bench SHALL cover: reset_n pulsed low with 5 entries stored -> out_valid=0 and match_count=0 immediately, state IDLE.
REQ-037 The bench SHALL cover: with DEDUP_EN, matches 0x20, 0x20, 0x21 -> stored 0x20, 0x21 and match_count=2; without DEDUP_EN -> three entries and match_count=3.
REQ-038 The bench SHALL cover: start while in DRAIN with 3 entries -> FIFO empty next cycle, state COLLECT, match_count=0.

Source files
------------

// File: rtl/psa_pkg.sv
// Shared definitions for the match collector: state encoding and default sizes.
package psa_pkg;

  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int COUNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/match_fifo.sv
// First-word-fall-through FIFO holding match addresses; pointers carry one
// extra wrap bit so full and empty are told apart by the MSB.
module match_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; emptiness is tracked by the
  // pointers alone, so stale contents can never reach rdata.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[IDX_W-1:0]] <= wdata;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                 (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);

  // Zero while empty keeps the output quiet after reset and flush.
  assign rdata = empty ? '0 : mem[rptr[IDX_W-1:0]];

endmodule

// File: rtl/match_collector.sv
// Collects match addresses from a search engine into a FIFO for a consumer.
// Optional: define MATCH_COLLECTOR_DEDUP_EN to drop back-to-back repeated addresses.
module match_collector
  import psa_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               CLK100MHZ,
  input  logic               reset_n,
  input  logic               start,
  input  logic               match_valid,
  input  logic [ADDR_W-1:0]  match_addr,
  input  logic               search_done,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [COUNT_W-1:0] match_count,
  output logic               overflow,
  output logic               run_done
);

  state_t state;
  state_t state_nxt;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic dup;
  logic offer;
  logic push;
  logic drop;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

`ifdef MATCH_COLLECTOR_DEDUP_EN
  logic [ADDR_W-1:0] last_addr;
  logic              last_valid;

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      last_addr  <= '0;
      last_valid <= 1'b0;
    end else if (start) begin
      last_valid <= 1'b0;
    end else if (push) begin
      last_addr  <= match_addr;
      last_valid <= 1'b1;
    end
  end

  assign dup = last_valid && (match_addr == last_addr);
`else
  assign dup = 1'b0;
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign offer = (state == ST_COLLECT) && match_valid && !start && !dup;
  assign push  = offer && (!fifo_full || pop);
  assign drop  = offer && fifo_full && !pop;

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: defaults first so every path assigns state_nxt and no latch forms.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_COLLECT;
    end else begin
      case (state)
        ST_COLLECT: if (search_done) state_nxt = ST_DRAIN;
        ST_DRAIN:   if (fifo_empty)  state_nxt = ST_DONE;
        default:    state_nxt = state;
      endcase
    end
  end

  // NOTE: registered state uses non-blocking assignments only.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      match_count <= '0;
      overflow    <= 1'b0;
    end else if (start) begin
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push && (match_count != '1)) match_count <= match_count + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  assign run_done = (state == ST_DONE);

  match_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clk   (CLK100MHZ),
    .rst_n (reset_n),
    .flush (start),
    .push  (push),
    .wdata (match_addr),
    .pop   (pop),
    .rdata (out_addr),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_match_collector.sv
// Self-checking bench for match_collector: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_match_collector;
  import psa_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 8;

  logic              CLK100MHZ;
  logic              reset_n;
  logic              start;
  logic              match_valid;
  logic [ADDR_W-1:0] match_addr;
  logic              search_done;
  logic              out_ready;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        match_count;
  logic              overflow;
  logic              run_done;

  match_collector #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK100MHZ   (CLK100MHZ),
    .reset_n     (reset_n),
    .start       (start),
    .match_valid (match_valid),
    .match_addr  (match_addr),
    .search_done (search_done),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_addr    (out_addr),
    .match_count (match_count),
    .overflow    (overflow),
    .run_done    (run_done)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an address queue plus run bookkeeping, stepped per edge.
  logic [ADDR_W-1:0] m_q[$];
  int                m_cnt    = 0;
  bit                m_ovf    = 0;
  state_t            m_state  = ST_IDLE;
  bit                m_last_v = 0;
  logic [ADDR_W-1:0] m_last   = '0;
  int                m_sz;
  bit                m_pop, m_dup, m_offer;

  initial begin
    forever begin
      @(posedge CLK100MHZ or negedge reset_n);
      if (!reset_n) begin
        m_q.delete();
        m_cnt = 0; m_ovf = 0; m_state = ST_IDLE; m_last_v = 0;
      end else if (start) begin
        m_q.delete();
        m_cnt = 0; m_ovf = 0; m_state = ST_COLLECT; m_last_v = 0;
      end else begin
        m_sz  = m_q.size();
        m_pop = (m_sz != 0) && out_ready;
        m_dup = 0;
`ifdef MATCH_COLLECTOR_DEDUP_EN
        m_dup = m_last_v && (match_addr == m_last);
`endif
        m_offer = (m_state == ST_COLLECT) && match_valid && !m_dup;
        if (m_pop) void'(m_q.pop_front());
        if (m_offer) begin
          if (m_sz < DEPTH || m_pop) begin
            m_q.push_back(match_addr);
            if (m_cnt < 255) m_cnt++;
            m_last = match_addr; m_last_v = 1;
          end else begin
            m_ovf = 1;
          end
        end
        if (m_state == ST_COLLECT && search_done) m_state = ST_DRAIN;
        else if (m_state == ST_DRAIN && m_sz == 0) m_state = ST_DONE;
      end
    end
  end

  always @(negedge CLK100MHZ) begin
    if (cmp_en) begin
      check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("out_addr", 32'(out_addr), 32'(m_q[0]));
      check("match_count", 32'(match_count), 32'(m_cnt));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("run_done", 32'(run_done), 32'(m_state == ST_DONE));
      check("state", 32'(dut.state), 32'(m_state));
    end
  end

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic done);
    match_valid = 1'b1; match_addr = a; search_done = done;
    tick();
    match_valid = 1'b0; search_done = 1'b0;
  endtask

  int n;
  logic [ADDR_W-1:0] last_seen;
  logic [ADDR_W-1:0] dd_exp [3];
  int dd_n;

  initial begin
    reset_n = 1'b0; start = 1'b0; match_valid = 1'b0; match_addr = '0;
    search_done = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge CLK100MHZ);
    #1 reset_n = 1'b1;
    cmp_en = 1;
    tick();
    check("rst out_valid", 32'(out_valid), 0);
    check("rst out_addr", 32'(out_addr), 0);
    check("rst match_count", 32'(match_count), 0);
    check("rst overflow", 32'(overflow), 0);
    check("rst run_done", 32'(run_done), 0);

    // Basic run: three matches drained in order.
    pulse_start();
    send(8'h05, 1'b0);
    send(8'h09, 1'b0);
    send(8'h11, 1'b1);
    check("t1 count", 32'(match_count), 3);
    check("t1 addr0", 32'(out_addr), 32'h05);
    out_ready = 1'b1;
    tick(); check("t1 addr1", 32'(out_addr), 32'h09);
    tick(); check("t1 addr2", 32'(out_addr), 32'h11);
    tick(); check("t1 empty", 32'(out_valid), 0);
    check("t1 not yet done", 32'(run_done), 0);
    tick(); check("t1 run_done", 32'(run_done), 1);
    out_ready = 1'b0;

    // Overflow: 18 matches into 16 slots with no consumer.
    pulse_start();
    for (int i = 0; i < 18; i++) send(8'(8'h40 + i), 1'b0);
    check("t2 count", 32'(match_count), 16);
    check("t2 overflow", 32'(overflow), 1);
    search_done = 1'b1; tick(); search_done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2 drain valid", 32'(out_valid), 1);
      check("t2 drain addr", 32'(out_addr), 32'(8'h40 + i));
      tick();
    end
    check("t2 drained", 32'(out_valid), 0);
    n = 0;
    while (!run_done && n < 10) begin tick(); n++; end
    check("t2 run_done reached", 32'(run_done), 1);
    out_ready = 1'b0;

    // Full FIFO with simultaneous push and pop.
    pulse_start();
    for (int i = 0; i < 16; i++) send(8'(8'h60 + i), 1'b0);
    check("t3 full count", 32'(match_count), 16);
    out_ready = 1'b1;
    send(8'h70, 1'b0);
    out_ready = 1'b0;
    check("t3 overflow", 32'(overflow), 0);
    check("t3 count", 32'(match_count), 17);
    check("t3 head", 32'(out_addr), 32'h61);
    search_done = 1'b1; out_ready = 1'b1;
    n = 0; last_seen = '0;
    while (out_valid && n < 40) begin
      last_seen = out_addr; n++;
      tick(); search_done = 1'b0;
    end
    search_done = 1'b0; out_ready = 1'b0;
    check("t3 occupancy", 32'(n), 16);
    check("t3 last", 32'(last_seen), 32'h70);

    // Reset mid-run with 5 entries stored.
    pulse_start();
    for (int i = 0; i < 5; i++) send(8'(8'h80 + i), 1'b0);
    check("t4 stored", 32'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    check("t4 out_valid", 32'(out_valid), 0);
    check("t4 count", 32'(match_count), 0);
    check("t4 state", 32'(dut.state), 32'(ST_IDLE));
    tick();
    reset_n = 1'b1;
    tick();
    check("t4 still empty", 32'(out_valid), 0);

    // Repeated address handling.
    pulse_start();
    send(8'h20, 1'b0);
    send(8'h20, 1'b0);
    send(8'h21, 1'b0);
`ifdef MATCH_COLLECTOR_DEDUP_EN
    dd_exp[0] = 8'h20; dd_exp[1] = 8'h21; dd_exp[2] = 8'h00; dd_n = 2;
`else
    dd_exp[0] = 8'h20; dd_exp[1] = 8'h20; dd_exp[2] = 8'h21; dd_n = 3;
`endif
    check("t5 count", 32'(match_count), 32'(dd_n));
    search_done = 1'b1; tick(); search_done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < dd_n; i++) begin
      check("t5 addr", 32'(out_addr), 32'(dd_exp[i]));
      tick();
    end
    check("t5 drained", 32'(out_valid), 0);
    out_ready = 1'b0;
    tick(); tick();

    // Abort during DRAIN.
    pulse_start();
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    send(8'h33, 1'b1);
    check("t6 drain state", 32'(dut.state), 32'(ST_DRAIN));
    check("t6 entries", 32'(out_valid), 1);
    pulse_start();
    check("t6 flushed", 32'(out_valid), 0);
    check("t6 count", 32'(match_count), 0);
    check("t6 state", 32'(dut.state), 32'(ST_COLLECT));
    tick(); tick();

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
